// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two issue ports and the ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_in1;
    logic [WIDTH-1:0] req0_in2;
    logic [3:0]       req0_control;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_in1;
    logic [WIDTH-1:0] req1_in2;
    logic [3:0]       req1_control;

    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_out;
    logic             resp_zero;
    logic             resp_neg;

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_control,
        output req1_valid, req1_in1, req1_in2, req1_control,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_out, resp_zero, resp_neg,
        output resp0_ready, resp1_ready
    );

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_control,
        input  req1_valid, req1_in1, req1_in2, req1_control,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_out, resp_zero, resp_neg,
        input  resp0_ready, resp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_neg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_grant;

    logic   grant_any;
    logic   grant_port;
    logic   idle_open;
    logic   owner_ready;

    // Contention goes to the port that did not win last time.
    always_comb begin
        grant_any  = bus.req0_valid | bus.req1_valid;
        grant_port = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    end

    assign idle_open   = reset_n && (state == IDLE);
    assign owner_ready = owner ? bus.resp1_ready : bus.resp0_ready;

    assign bus.req0_ready  = idle_open && grant_any && !grant_port;
    assign bus.req1_ready  = idle_open && grant_port;
    assign bus.resp0_valid = reset_n && (state == RESP) && !owner;
    assign bus.resp1_valid = reset_n && (state == RESP) && owner;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_control   <= 4'h0;
            bus.resp_out  <= '0;
            bus.resp_zero <= 1'b0;
            bus.resp_neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_in1     <= grant_port ? bus.req1_in1     : bus.req0_in1;
                        alu_in2     <= grant_port ? bus.req1_in2     : bus.req0_in2;
                        alu_control <= grant_port ? bus.req1_control : bus.req0_control;
                        owner       <= grant_port;
                        last_grant  <= grant_port;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    bus.resp_out  <= alu_out;
                    bus.resp_zero <= alu_zero;
                    bus.resp_neg  <= alu_neg;
                    state         <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_control;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_neg;

    int vectors = 0;
    int miscompares = 0;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external alu block.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h1: return a << b[4:0];
            4'h2: return {31'd0, $signed(a) < $signed(b)};
            4'h3: return {31'd0, a < b};
            4'h4: return a ^ b;
            4'h5: return a >> b[4:0];
            4'hD: return $unsigned($signed(a) >>> b[4:0]);
            4'h6: return a | b;
            4'h7: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_fn(alu_in1, alu_in2, alu_control);
        alu_zero = (alu_out == 32'd0);
        alu_neg  = alu_out[31];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid   = 1'b0;
        bus.req1_valid   = 1'b0;
        bus.req0_in1     = 32'd0;
        bus.req0_in2     = 32'd0;
        bus.req0_control = 4'h0;
        bus.req1_in1     = 32'd0;
        bus.req1_in2     = 32'd0;
        bus.req1_control = 4'h0;
        bus.resp0_ready  = 1'b0;
        bus.resp1_ready  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic load0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_control = c;
    endtask

    task automatic load1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_control = c;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();

        // Reset state, including ready suppressed while reset is held.
        bus.req0_valid = 1'b1;
        #1;
        check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        check("rst_resp0_valid", {31'd0, bus.resp0_valid}, 32'd0);
        check("rst_resp1_valid", {31'd0, bus.resp1_valid}, 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_alu_control", {28'd0, alu_control}, 32'd0);
        check("rst_resp_out", bus.resp_out, 32'd0);
        check("rst_flags", {30'd0, bus.resp_zero, bus.resp_neg}, 32'd0);
        bus.req0_valid = 1'b0;
        reset_n = 1'b1;
        step();

        // Port 0 alone: 5 + 7.
        load0(32'd5, 32'd7, 4'h0);
        bus.req0_valid = 1'b1;
        #1;
        check("t1_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("t1_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0;
        check("t1_exec_alu_in1", alu_in1, 32'd5);
        check("t1_exec_alu_in2", alu_in2, 32'd7);
        check("t1_exec_resp0_valid", {31'd0, bus.resp0_valid}, 32'd0);
        step();
        check("t1_resp0_valid", {31'd0, bus.resp0_valid}, 32'd1);
        check("t1_resp1_valid", {31'd0, bus.resp1_valid}, 32'd0);
        check("t1_resp_out", bus.resp_out, 32'd12);
        check("t1_flags", {30'd0, bus.resp_zero, bus.resp_neg}, 32'd0);
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;
        check("t1_after_resp0_valid", {31'd0, bus.resp0_valid}, 32'd0);

        // Contention from a fresh reset: port 0 first, then port 1.
        do_reset();
        load0(32'd3, 32'd3, 4'h8);
        load1(32'h8000_0000, 32'd4, 4'hD);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("t2_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("t2_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0;
        step();
        check("t2_resp0_valid", {31'd0, bus.resp0_valid}, 32'd1);
        check("t2_resp0_out", bus.resp_out, 32'd0);
        check("t2_resp0_flags", {30'd0, bus.resp_zero, bus.resp_neg}, 32'd2);
        check("t2_req1_ready_resp", {31'd0, bus.req1_ready}, 32'd0);
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;
        #1;
        check("t2_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 1'b0;
        step();
        check("t2_resp1_valid", {31'd0, bus.resp1_valid}, 32'd1);
        check("t2_resp0_valid_off", {31'd0, bus.resp0_valid}, 32'd0);
        check("t2_resp1_out", bus.resp_out, 32'hF800_0000);
        check("t2_resp1_flags", {30'd0, bus.resp_zero, bus.resp_neg}, 32'd1);
        bus.resp1_ready = 1'b1;
        step();
        bus.resp1_ready = 1'b0;

        // Continuous contention with responses always accepted.
        load0(32'd2, 32'd3, 4'h0);
        load1(32'd100, 32'd200, 4'h0);
        bus.req0_valid  = 1'b1;
        bus.req1_valid  = 1'b1;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] exp_rdy;
            logic [1:0] exp_rsp;
            logic       port;
            port    = ((c / 3) % 2) != 0;
            exp_rdy = (c % 3 == 0) ? (port ? 2'b10 : 2'b01) : 2'b00;
            exp_rsp = (c % 3 == 2) ? (port ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("t3_ready_c%0d", c), {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, exp_rdy});
            check($sformatf("t3_resp_c%0d", c), {30'd0, bus.resp1_valid, bus.resp0_valid}, {30'd0, exp_rsp});
            if (c % 3 == 2)
                check($sformatf("t3_out_c%0d", c), bus.resp_out, port ? 32'd300 : 32'd5);
            step();
        end
        idle_inputs();

        // Backpressure on port 1 while port 0 keeps asking.
        load1(32'hFFFF_FFFF, 32'd1, 4'h3);
        load0(32'd1, 32'd2, 4'h0);
        bus.req1_valid = 1'b1;
        #1;
        check("t4_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4_resp1_valid_%0d", c), {31'd0, bus.resp1_valid}, 32'd1);
            check($sformatf("t4_resp_out_%0d", c), bus.resp_out, 32'd0);
            check($sformatf("t4_readys_%0d", c), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            step();
        end
        bus.resp1_ready = 1'b1;
        #1;
        check("t4_req0_ready_hs", {31'd0, bus.req0_ready}, 32'd0);
        step();
        bus.resp1_ready = 1'b0;
        #1;
        check("t4_req0_ready_idle", {31'd0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        step();
        check("t4_resp0_out", bus.resp_out, 32'd3);
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;

        // Reset while in EXEC discards the operation.
        load0(32'd77, 32'd1, 4'h0);
        bus.req0_valid = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t5_rst_resp_valid", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        step();
        reset_n = 1'b1;
        check("t5_alu_in1", alu_in1, 32'd0);
        check("t5_alu_control", {28'd0, alu_control}, 32'd0);
        check("t5_resp_out", bus.resp_out, 32'd0);
        check("t5_resp_valid", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        step();
        check("t5_no_pulse", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        load0(32'd9, 32'd4, 4'h8);
        load1(32'd1, 32'd1, 4'h0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("t5_prio_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        check("t5_resp0_valid", {31'd0, bus.resp0_valid}, 32'd1);
        check("t5_resp0_out", bus.resp_out, 32'd5);
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;

        // Undefined opcode from port 1.
        load1(32'd123, 32'd456, 4'hF);
        bus.req1_valid = 1'b1;
        #1;
        check("t6_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 1'b0;
        step();
        check("t6_resp1_valid", {31'd0, bus.resp1_valid}, 32'd1);
        check("t6_resp_out", bus.resp_out, 32'd0);
        check("t6_flags", {30'd0, bus.resp_zero, bus.resp_neg}, 32'd2);
        bus.resp1_ready = 1'b1;
        step();
        bus.resp1_ready = 1'b0;
        check("t6_resp1_done", {31'd0, bus.resp1_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters (port 0, port 1) with valid/ready handshakes on request and response. Round-robin arbitration, one operation in flight at a time. Operands and control are registered into the ALU; the result and flags are captured and held until the owning requester accepts them. Sits between the issue logic and the `alu` instance, which it drives directly.

## Interface
- `WIDTH`, 32, datapath width; fixed to match `alu`.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when high together with valid.
- `req0_in1`, `req0_in2` / `req1_in1`, `req1_in2` in WIDTH: operands.
- `req0_control` / `req1_control` in 4: ALU operation code, passed through unmodified.
- `resp0_valid` / `resp1_valid` out 1: result available for that port.
- `resp0_ready` / `resp1_ready` in 1: requester accepts the result.
- `resp_out` out WIDTH: result, shared by both ports.
- `resp_zero` out 1: zero flag, shared by both ports.
- `resp_neg` out 1: negative flag, shared by both ports.
- `alu_in1`, `alu_in2` out WIDTH: registered operands to `alu`.
- `alu_control` out 4: registered control to `alu`.
- `alu_out` in WIDTH: result from `alu`.
- `alu_zero` in 1: zero flag from `alu`.
- `alu_neg` in 1: negative flag from `alu`.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers: `state`, `owner` (1 bit), `last_grant` (1 bit).
- IDLE:
  - Only state in which any `reqX_ready` may be high.
  - Grant: one valid → that port. Both valid → port != `last_grant`.
  - `reqX_ready` is high for the granted port only. It is combinational from the valids and `last_grant`.
  - On acceptance:
    - Latch operands and control into `alu_in1`/`alu_in2`/`alu_control`.
    - `owner` ← granted port; `last_grant` ← granted port.
    - Next state EXEC.
  - No valid → stay in IDLE; ALU input registers hold their last values.
- EXEC (exactly 1 cycle): capture `alu_out`/`alu_zero`/`alu_neg` into the `resp_*` registers; next state RESP.
- RESP:
  - `resp<owner>_valid` = 1; the other response valid = 0.
  - `resp_*` held stable.
  - On `resp<owner>_ready` = 1 → IDLE. Otherwise stay in RESP.
  - `resp` of the non-owner port is ignored.
- No new request is accepted in the same cycle as a response handshake.
- Opcodes are not checked. Undefined codes yield whatever `alu` produces (0, zero = 1).
- Reset values:
  - state = IDLE.
  - `last_grant` = 1, so port 0 wins the first contention.
  - `owner` = 0.
  - `alu_in1` = `alu_in2` = 0, `alu_control` = 0.
  - `resp_out` = 0, `resp_zero` = 0, `resp_neg` = 0.
  - All `reqX_ready` and `respX_valid` = 0 during reset.
- Reset in EXEC or RESP: in-flight operation discarded, no response issued, all reset values restored next cycle.

## Timing
- Request handshake at cycle N.
- N+1: EXEC; ALU inputs valid, ALU result settles combinationally.
- N+2: `respX_valid` = 1, `resp_*` valid. Minimum latency is 2 cycles.
- Response handshake at cycle M ≥ N+2: back in IDLE at M+1; next acceptance earliest at M+1.
- Peak throughput: 1 operation per 3 cycles.
- Valid/ready rules:
  - A request once raised must be held with stable payload until ready. The arbiter does not check this.
  - `respX_valid` never drops without a handshake, except on reset.
- `reqX_ready` is never high outside IDLE, regardless of valids.

## Test plan
- Port 0 alone, `in1`=5, `in2`=7, `control`=0x0 (add) → `req0_ready` at N; `resp0_valid` at N+2 with `resp_out`=12, zero=0, neg=0; `resp1_valid` stays 0.
- Both ports valid in the same IDLE cycle:
  - Stimulus: port 0 3−3 (`control`=0x8); port 1 0x80000000 sra 4 (`control`=0xD).
  - Port 0 first: `resp_out`=0, zero=1.
  - Then port 1: `resp_out`=0xF8000000, neg=1.
- Both valid continuously for 4 operations with `resp_ready` tied high → grant order 0,1,0,1; each response exactly 2 cycles after its acceptance; acceptances 3 cycles apart.
- Backpressure on port 1 (`in1`=0xFFFFFFFF, `in2`=1, `control`=0x3 sltu):
  - Hold `resp1_ready` low 5 cycles → `resp1_valid` high and `resp_out`=0 stable throughout.
  - Both `reqX_ready` stay 0 even with `req0_valid` high.
- `reset_n` low in EXEC → next cycle all outputs at reset values; no `respX_valid` pulse; following request accepted normally with port 0 priority.
- Undefined opcode 0xF from port 1 → `resp_out`=0, zero=1, neg=0; handshake completes normally.
